// File: rtl/psum_drain_ctrl_pkg.sv
// Shared types and helpers for the accumulator drain controller: FSM states,
// column slice placement within a row, and the signed ReLU applied on capture.
package psum_drain_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Psum word width the relu helper operates on; DATA_WIDTH is expected to match.
    localparam int PSUM_W = 32;

    // Column 0 occupies the most significant slice of a row.
    function automatic int col_lsb(input int col, input int pe_size, input int dw);
        return (pe_size - 1 - col) * dw;
    endfunction

    function automatic logic [PSUM_W-1:0] relu(input logic signed [PSUM_W-1:0] word);
        return (word < 0) ? '0 : word;
    endfunction

endpackage

// File: rtl/psum_drain_ctrl_if.sv
// Accumulator-FIFO read port and GLB write port of the drain controller;
// the master modport is the controller side.
interface psum_drain_ctrl_if #(
    parameter int PE_SIZE    = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
);

    logic [PE_SIZE-1:0]            acc_rden_o;
    logic [DATA_WIDTH*PE_SIZE-1:0] acc_rdata_i;
    logic                          glb_wren_o;
    logic                          glb_ready_i;
    logic [ADDR_WIDTH-1:0]         glb_addr_o;
    logic [DATA_WIDTH*PE_SIZE-1:0] glb_wdata_o;

    modport master (
        output acc_rden_o,
        input  acc_rdata_i,
        output glb_wren_o,
        input  glb_ready_i,
        output glb_addr_o,
        output glb_wdata_o
    );

    modport slave (
        input  acc_rden_o,
        output acc_rdata_i,
        input  glb_wren_o,
        output glb_ready_i,
        input  glb_addr_o,
        input  glb_wdata_o
    );

endinterface

// File: rtl/psum_row_skid_buf.sv
// Two-entry row buffer between FIFO read data and the GLB write port. The
// producer never pushes into a full buffer: it gates its reads on occ_o.
module psum_row_skid_buf #(
    parameter int WIDTH = 512
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid_i,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    input  logic             m_ready_i,
    output logic [1:0]       occ_o
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_cnt;
    logic             w_pop;

    assign m_valid_o = (r_cnt != 2'd0);
    assign m_data_o  = r_mem[r_rd_ptr];
    assign occ_o     = r_cnt;
    assign w_pop     = m_valid_o & m_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the two data entries are reset too, so glb_wdata_o reads 0 during reset.
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_cnt    <= 2'd0;
        end else begin
            if (s_valid_i) begin
                r_mem[r_wr_ptr] <= s_data_i;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({s_valid_i, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/psum_drain_ctrl.sv
// Drains accumulated partial-sum rows from the column FIFOs in lock-step,
// optionally applies ReLU, and writes them to consecutive GLB addresses.
module psum_drain_ctrl
    import psum_drain_ctrl_pkg::*;
#(
    parameter int PE_SIZE    = 16,
    parameter int DATA_WIDTH = PSUM_W,
    parameter int FIFO_DEPTH = 64,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic [$clog2(FIFO_DEPTH):0] num_rows_i,
    input  logic [ADDR_WIDTH-1:0]       base_addr_i,
    input  logic                        relu_en_i,
    output logic                        busy_o,
    output logic                        done_o,
    psum_drain_ctrl_if.master           bus
);

    localparam int                CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int                ROW_W    = DATA_WIDTH * PE_SIZE;
    localparam logic [CNT_W-1:0]  MAX_ROWS = CNT_W'(FIFO_DEPTH);

    state_e                r_state;
    state_e                w_next_state;
    logic [CNT_W-1:0]      r_num_rows;
    logic [CNT_W-1:0]      r_rd_cnt;
    logic [CNT_W-1:0]      r_wr_cnt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic                  r_relu;
    logic                  r_inflight;
    logic [CNT_W-1:0]      w_num_clamped;
    logic                  w_start;
    logic                  w_rden;
    logic                  w_pop;
    logic                  w_last_pop;
    logic                  w_head_valid;
    logic [1:0]            w_occ;
    logic [2:0]            w_credit_used;
    logic [ROW_W-1:0]      w_push_data;
    logic [ROW_W-1:0]      w_head_data;

    assign w_start       = start_i && (r_state == ST_IDLE);
    assign w_num_clamped = (num_rows_i > MAX_ROWS) ? MAX_ROWS : num_rows_i;
    assign w_pop         = w_head_valid & bus.glb_ready_i;
    assign w_last_pop    = w_pop && (r_wr_cnt == r_num_rows - CNT_W'(1));
    // A pop this cycle frees a slot before the new read's data lands, keeping one row per cycle.
    assign w_credit_used = 3'(w_occ) + 3'(r_inflight) - 3'(w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns it and no latch is inferred.
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:  if (start_i) w_next_state = (w_num_clamped == '0) ? ST_DONE : ST_DRAIN;
            ST_DRAIN: if (w_last_pop) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rden = 1'b0;
        busy_o = 1'b0;
        done_o = 1'b0;
        case (r_state)
            ST_DRAIN: begin
                busy_o = 1'b1;
                w_rden = (r_rd_cnt < r_num_rows) && (w_credit_used < 3'd2);
            end
            ST_DONE:  done_o = 1'b1;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_rows <= '0;
            r_rd_cnt   <= '0;
            r_wr_cnt   <= '0;
            r_base     <= '0;
            r_relu     <= 1'b0;
            r_inflight <= 1'b0;
        end else begin
            if (w_start) begin
                r_num_rows <= w_num_clamped;
                r_base     <= base_addr_i;
                r_relu     <= relu_en_i;
                r_rd_cnt   <= '0;
                r_wr_cnt   <= '0;
            end else begin
                if (w_rden) r_rd_cnt <= r_rd_cnt + CNT_W'(1);
                if (w_pop)  r_wr_cnt <= r_wr_cnt + CNT_W'(1);
            end
            r_inflight <= w_rden;
        end
    end

    for (genvar c = 0; c < PE_SIZE; c++) begin : g_col
        localparam int LSB = col_lsb(c, PE_SIZE, DATA_WIDTH);
        logic [DATA_WIDTH-1:0] w_word;
        assign w_word                         = bus.acc_rdata_i[LSB +: DATA_WIDTH];
        assign w_push_data[LSB +: DATA_WIDTH] = r_relu ? relu(w_word) : w_word;
    end

    psum_row_skid_buf #(
        .WIDTH (ROW_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid_i (r_inflight),
        .s_data_i  (w_push_data),
        .m_valid_o (w_head_valid),
        .m_data_o  (w_head_data),
        .m_ready_i (bus.glb_ready_i),
        .occ_o     (w_occ)
    );

    assign bus.acc_rden_o  = {PE_SIZE{w_rden}};
    assign bus.glb_wren_o  = w_head_valid;
    assign bus.glb_wdata_o = w_head_data;
    assign bus.glb_addr_o  = r_base + ADDR_WIDTH'(r_wr_cnt);

endmodule
